lsu_mem_master: RTL
===================

// Module: lsu_mem_master
// PURPOSE
// - Load/store initiator between the multicycle RV32 core and the byte-addressed unified memory.
// - Accepts one load/store request at a time and drives the memory read/write strobes, word address and write data.
// - Performs byte/halfword lane extraction with sign/zero extension on loads.
// - Performs read-modify-write for SB/SH, because the memory always writes 4 bytes at address..address+3.
// PARAMETERS
// - MEM_BYTES     1024  memory size in bytes; accesses with addr+size > MEM_BYTES are errors
// - READ_LATENCY  1     cycles from mem_read sample edge to mem_rdata valid (legal 1..4)
// PORTS
// - clk         in   1   clock, rising edge
// - reset       in   1   asynchronous, active-high reset
// - req_valid   in   1   request present
// - req_ready   out  1   1 only in IDLE; request accepted at posedge with req_valid&req_ready
// - req_we      in   1   1=store, 0=load
// - req_funct3  in   3   RV32 funct3: LB000 LH001 LW010 LBU100 LHU101 / SB000 SH001 SW010
// - req_addr    in   32  byte address
// - req_wdata   in   32  store data, LSB-aligned (byte in [7:0], half in [15:0])
// - resp_valid  out  1   one-cycle completion pulse, no backpressure
// - resp_err    out  1   valid with resp_valid; illegal funct3 / out of range / misaligned
// - resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores/errors
// - mem_read    out  1   memory read strobe
// - mem_write   out  1   memory write strobe
// - mem_addr    out  32  memory address, always word-aligned (addr & ~3)
// - mem_wdata   out  32  memory write data, little-endian
// - mem_rdata   in   32  memory read data, little-endian
// BEHAVIOUR
// - Reset (async): state=IDLE; all outputs 0 except req_ready=1; capture/merge regs=0, latency counter=0.
// - States: IDLE, RD, RWAIT, WR, RESP.
// - IDLE: on accept, latch we/funct3/addr/wdata and check legality.
//   - Illegal -> RESP with err=1; no memory strobe.
//   - Load or SB/SH -> RD.
//   - SW -> WR.
// - RD: mem_read=1 for exactly one cycle, mem_addr=aligned addr -> RWAIT, counter=READ_LATENCY.
// - RWAIT: decrement counter; when counter==1, capture mem_rdata at that edge.
//   - Load -> RESP.
//   - SB/SH -> WR with merged word: replace byte lane addr[1:0] or half lane addr[1], keep other bytes.
// - WR: mem_write=1 for exactly one cycle.
//   - mem_wdata = merged word (SB/SH) or req_wdata (SW).
//   - -> RESP.
// - RESP: resp_valid=1 one cycle -> IDLE; req_ready returns 1 the next cycle.
// - Latency (cycles after accept edge, READ_LATENCY=1):
//   - error: 1
//   - SW: 2
//   - load: 3
//   - SB/SH: 4
//   - each extra READ_LATENCY cycle adds 1 to load and SB/SH.
// - Load extension:
//   - LB/LH sign-extend bit 7/15 of the selected lane.
//   - LBU/LHU zero-extend.
//   - LW passes the word through.
// - mem_addr/mem_wdata hold their last value outside RD/WR; strobes are never both 1.
// - Reset mid-operation aborts immediately: no strobe after reset asserts, no resp_valid for the aborted request.
// - req_valid while busy is ignored; the request is not queued.
// CONFIGURATION
// - MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, -> resp_err=1, no memory access.
// - MISALIGN_CHECK_EN undefined: misalignment is not an error.
//   - Halfword uses lane addr[1] (addr[0] ignored).
//   - Word ignores addr[1:0].
// - Range and funct3 checks are always present.
// TESTING (model preload: bytes 0x20..0x23 = BB AA 99 88; READ_LATENCY=1)
// - LW 0x20 -> one mem_read at mem_addr 0x20; resp_valid 3 cycles after accept; rdata 0x8899AABB, err 0.
// - LB/LBU 0x22 -> 0xFFFFFF99 / 0x00000099; LH 0x22 -> 0xFFFF8899; LHU 0x20 -> 0x0000AABB.
// - SB 0x21 wdata 0x12345677 -> mem_read 0x20, then mem_write 0x20 data 0x889977BB; LW 0x20 -> 0x889977BB.
// - SH 0x23: with MISALIGN_CHECK_EN -> err=1 one cycle after accept, no strobes; without -> writes lane 0x22.
// - LW 0x400 or funct3=011 -> resp_err=1, no strobes; READ_LATENCY=3 LW 0x20 -> resp 5 cycles after accept.
// - reset pulsed in RWAIT of SB -> mem_write never asserts, no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: request/response and memory bus bundle for the load/store initiator
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator with sub-word read-modify-write.
// Define MISALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module lsu_mem_master #(
    parameter int MEM_BYTES    = 1024,
    parameter int READ_LATENCY = 1
) (
    input logic               clk,
    input logic               reset,
    lsu_mem_master_if.master  bus
);
    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, RESP} state_t;
    state_t      state, state_n;
    logic        we_q, err_q;
    logic [2:0]  f3_q, cnt_q, size;
    logic [1:0]  lo_q;
    logic [15:0] wd_q;
    logic [31:0] rdata_q, maddr_q, mwdata_q, mask, merged, ld_val;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;
    logic [4:0]  sh_b, sh_h, sh_w;
    logic        accept, bad_f3, bad_range, misalign, illegal, is_sw;
    assign accept    = bus.req_valid && state == IDLE;
    assign size      = bus.req_funct3[1:0] == 2'b00 ? 3'd1 : bus.req_funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    assign bad_f3    = bus.req_funct3[1:0] == 2'b11 || (bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1]));
    assign bad_range = ({1'b0, bus.req_addr} + {30'b0, size}) > 33'(MEM_BYTES);
`ifdef MISALIGN_CHECK_EN
    assign misalign  = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    assign misalign  = 1'b0;
`endif
    assign illegal   = bad_f3 || bad_range || misalign;
    assign is_sw     = bus.req_we && bus.req_funct3 == 3'b010;
    // Lane selection is done on the raw memory word in the capture cycle
    assign sh_b   = {lo_q, 3'b000};
    assign sh_h   = {lo_q[1], 4'b0000};
    assign sh_w   = f3_q[0] ? sh_h : sh_b;
    assign rd_b   = 8'(bus.mem_rdata >> sh_b);
    assign rd_h   = 16'(bus.mem_rdata >> sh_h);
    assign ld_val = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & rd_b[7]}}, rd_b} :
                    f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & rd_h[15]}}, rd_h} : bus.mem_rdata;
    assign mask   = f3_q[0] ? 32'h0000_FFFF << sh_h : 32'h0000_00FF << sh_b;
    assign merged = (bus.mem_rdata & ~mask) | (({16'b0, wd_q} << sh_w) & mask);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = illegal ? RESP : is_sw ? WR : RD;
            RD:      state_n = RWAIT;
            RWAIT:   if (cnt_q == 3'd1) state_n = we_q ? WR : RESP;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            lo_q     <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                lo_q    <= bus.req_addr[1:0];
                wd_q    <= bus.req_wdata[15:0];
                err_q   <= illegal;
                rdata_q <= '0;
                if (!illegal) maddr_q <= {bus.req_addr[31:2], 2'b00};
                if (!illegal && is_sw) mwdata_q <= bus.req_wdata;
            end
            if (state == RD) cnt_q <= 3'(READ_LATENCY);
            if (state == RWAIT) begin
                cnt_q <= cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (we_q) mwdata_q <= merged;
                    else rdata_q <= ld_val;
                end
            end
        end
    end
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_err   = state == RESP && err_q;
    assign bus.resp_rdata = state == RESP ? rdata_q : 32'h0;
    assign bus.mem_read   = state == RD;
    assign bus.mem_write  = state == WR;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = mwdata_q;
endmodule
